fifo_wrapper: RTL and testbench
===============================

FIFO_WRAPPER -- requirements
Module: fifo_wrapper

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: data word width in bits (legal range 1 or more).
REQ-002 The block SHALL have parameter DEPTH, default 128: storage capacity in words (power of two, 2 or more).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port input_data, input, WIDTH bits: write-side data word.
REQ-006 The block SHALL have port input_valid, input, 1 bit: the upstream offers input_data this cycle.
REQ-007 The block SHALL have port input_ready, output, 1 bit: the FIFO accepts a word this cycle.
REQ-008 The block SHALL have port output_data, output, WIDTH bits: the word at the head of the FIFO.
REQ-009 The block SHALL have port output_valid, output, 1 bit: output_data holds a valid head word.
REQ-010 The block SHALL have port output_ready, input, 1 bit: the downstream consumes the head word this cycle.

Function
REQ-011 A push SHALL occur on a rising clk edge when input_valid=1 and input_ready=1; the word is written at the write pointer and the write pointer increments modulo DEPTH.
REQ-012 A pop SHALL occur on a rising clk edge when output_valid=1 and output_ready=1; the read pointer increments modulo DEPTH.
REQ-013 The occupancy count SHALL be ($clog2(DEPTH)+1) bits wide; push only adds 1, pop only subtracts 1, push and pop together leave it unchanged.
REQ-014 input_ready SHALL equal (count != DEPTH) while reset is low, and SHALL be 0 while reset is high.
REQ-015 When the FIFO is full, a simultaneous pop SHALL NOT enable a same-cycle push (no full-bypass).
REQ-016 output_valid SHALL equal (count != 0). The FIFO is first-word-fall-through: output_data SHALL show the head word combinationally from storage whenever output_valid=1.
REQ-017 Write-to-read latency SHALL be 1 cycle: a word pushed into an empty FIFO at edge N is visible with output_valid=1 after edge N and may be popped at edge N+1.
REQ-018 When the FIFO is empty, a simultaneous push SHALL NOT be consumed in the same cycle (no empty-bypass).
REQ-019 output_data SHALL remain stable while output_valid=1 and output_ready=0.
REQ-020 When output_valid=0, output_data is don't-care and SHALL NOT be checked.
REQ-021 Words SHALL leave the FIFO in strict arrival order with no loss or duplication. Both pointers SHALL wrap from DEPTH-1 to 0 seamlessly.
REQ-022 input_valid with input_ready=0 SHALL have no effect. output_ready with output_valid=0 SHALL have no effect.

Reset
REQ-023 While reset=1, asynchronously: the write pointer, read pointer and count SHALL be 0, output_valid SHALL be 0, and input_ready SHALL be 0.
REQ-024 On the first edge after reset falls, input_ready SHALL be 1. Storage contents need not be cleared.
REQ-025 Reset asserted mid-operation SHALL discard all stored words immediately.

Configuration
REQ-026 The macro FIFO_WRAPPER_CHECK_EN SHALL control simulation checking.
- When defined: on each rising clk edge the block SHALL print an error message and halt simulation if count exceeds DEPTH, or if output_data changes while output_valid=1 and output_ready=0.
- When undefined: no checking logic is compiled in, and the functional behaviour is identical.

Verification
REQ-027 Reset, then push 0x01..0x05 with output_ready=0 -> count=5, output_valid=1, output_data=0x01 held stable.
REQ-028 With WIDTH=8 and DEPTH=128, push 128 words -> input_ready=0. Hold input_valid=1 and output_ready=1 for one cycle -> exactly one pop occurs and no push occurs.
REQ-029 Stream 300 words with input_valid=1 and output_ready=1 continuously -> the output sequence equals the input sequence and the pointers wrap twice.
REQ-030 Push 0xA5 into an empty FIFO with output_ready=1 -> output_valid rises 1 cycle later and 0xA5 is popped on the next edge; the FIFO is then empty.
REQ-031 Assert reset asynchronously with 10 words stored -> output_valid=0 and input_ready=0 immediately; after release, count=0.
REQ-032 Drive random valid/ready patterns for 10,000 cycles -> scoreboard order matches and no FIFO_WRAPPER_CHECK_EN error is reported.

Source files
------------

// File: rtl/fifo_wrapper.sv
// First-word-fall-through FIFO, WIDTH x DEPTH, single clock, async active-high reset.
// Latency: 1 cycle write-to-read; no full or empty bypass. Backpressure: input_ready low when full or in reset.
// Optional simulation checking compiled in with FIFO_WRAPPER_CHECK_EN.
module fifo_wrapper #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] input_data,
  input  logic             input_valid,
  output logic             input_ready,
  output logic [WIDTH-1:0] output_data,
  output logic             output_valid,
  input  logic             output_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  // Ready is gated by reset directly so it drops the instant reset rises.
  assign input_ready  = !reset && (count != FULL_CNT);
  assign output_valid = (count != '0);
  assign output_data  = mem[rd_ptr];
  assign push         = input_valid && input_ready;
  assign pop          = output_valid && output_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= input_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

`ifdef FIFO_WRAPPER_CHECK_EN
  logic             hold_q;
  logic [WIDTH-1:0] data_q;

  always @(posedge clk) begin
    if (!reset) begin
      if (count > FULL_CNT) begin
        $display("fifo_wrapper error: count %0d exceeds depth %0d", count, DEPTH);
        $fatal(1);
      end
      if (hold_q && output_valid && (output_data != data_q)) begin
        $display("fifo_wrapper error: output_data changed while stalled");
        $fatal(1);
      end
    end
    hold_q <= !reset && output_valid && !output_ready;
    data_q <= output_data;
  end
`else
`endif

endmodule

// File: tb/tb_fifo_wrapper.sv
// Randomised bench for fifo_wrapper against a queue-based reference model.
module tb_fifo_wrapper;

  localparam int WIDTH = 8;
  localparam int DEPTH = 128;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] input_data;
  logic             input_valid;
  logic             input_ready;
  logic [WIDTH-1:0] output_data;
  logic             output_valid;
  logic             output_ready;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] mq[$];
  int pushes = 0;
  int pops   = 0;

  fifo_wrapper #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .input_data   (input_data),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .output_data  (output_data),
    .output_valid (output_valid),
    .output_ready (output_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a word is accepted when offered, not in reset and fewer than DEPTH are held;
  // the head leaves when something is held and the consumer is ready.
  task automatic drive_cycle(input logic iv, input logic [WIDTH-1:0] d, input logic ordy);
    logic dp;
    logic dq;
    input_valid  = iv;
    input_data   = d;
    output_ready = ordy;
    dp = iv && !reset && (mq.size() < DEPTH);
    dq = ordy && !reset && (mq.size() > 0);
    @(posedge clk);
    #1;
    if (dq) begin
      void'(mq.pop_front());
      pops++;
    end
    if (dp) begin
      mq.push_back(d);
      pushes++;
    end
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    input_valid  = 1'b0;
    output_ready = 1'b0;
    input_data   = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    mq.delete();
    pushes = 0;
    pops   = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    input_valid = 1'b0; output_ready = 1'b0; input_data = '0;
    #12;
    checks++;
    if (output_valid !== 1'b0) begin
      errors++; $display("FAIL reset_ov: got %b want 0", output_valid);
    end
    checks++;
    if (input_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ir: got %b want 0", input_ready);
    end
    checks++;
    if (dut.count !== '0) begin
      errors++; $display("FAIL reset_count: got %0d want 0", dut.count);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    drive_cycle(1'b0, '0, 1'b0);
    checks++;
    if (input_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ir: got %b want 1", input_ready);
    end
  endtask

  task automatic test_hold();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      drive_cycle(1'b1, WIDTH'(i), 1'b0);
    end
    checks++;
    if (dut.count !== (DEPTH == 0 ? 0 : mq.size())) begin
      errors++; $display("FAIL hold_count: got %0d want %0d", dut.count, mq.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (output_valid !== 1'b1 || output_data !== mq[0]) begin
        errors++;
        $display("FAIL hold_head: got ov=%b data=%h want ov=1 data=%h", output_valid, output_data, mq[0]);
      end
      drive_cycle(1'b0, '0, 1'b0);
    end
  endtask

  task automatic test_full_no_bypass();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive_cycle(1'b1, WIDTH'($urandom), 1'b0);
    end
    checks++;
    if (input_ready !== (mq.size() != DEPTH)) begin
      errors++; $display("FAIL full_ir: got %b want %b", input_ready, mq.size() != DEPTH);
    end
    drive_cycle(1'b1, 8'hEE, 1'b1);
    checks++;
    if (dut.count !== mq.size()) begin
      errors++; $display("FAIL full_pop_only: got count %0d want %0d", dut.count, mq.size());
    end
    while (mq.size() > 0) begin
      checks++;
      if (output_valid !== 1'b1 || output_data !== mq[0]) begin
        errors++;
        $display("FAIL full_drain: got ov=%b data=%h want ov=1 data=%h", output_valid, output_data, mq[0]);
      end
      drive_cycle(1'b0, '0, 1'b1);
    end
    checks++;
    if (output_valid !== 1'b0) begin
      errors++; $display("FAIL full_drained_ov: got %b want 0", output_valid);
    end
  endtask

  task automatic test_stream();
    logic [WIDTH-1:0] sent[$];
    logic [WIDTH-1:0] got[$];
    logic [WIDTH-1:0] d;
    int bad;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      d = WIDTH'($urandom);
      sent.push_back(d);
      output_ready = 1'b1;
      if (output_valid) got.push_back(output_data);
      drive_cycle(1'b1, d, 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      if (output_valid) got.push_back(output_data);
      drive_cycle(1'b0, '0, 1'b1);
    end
    checks++;
    if (got.size() != 300) begin
      errors++; $display("FAIL stream_len: got %0d want 300", got.size());
    end
    bad = 0;
    for (int i = 0; i < 300 && i < got.size(); i++) begin
      if (got[i] !== sent[i]) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL stream_order: got %0d mismatched words want 0", bad);
    end
    checks++;
    if (dut.rd_ptr !== 7'(pops % DEPTH) || dut.wr_ptr !== 7'(pushes % DEPTH)) begin
      errors++;
      $display("FAIL stream_wrap: got rd=%0d wr=%0d want rd=%0d wr=%0d",
               dut.rd_ptr, dut.wr_ptr, pops % DEPTH, pushes % DEPTH);
    end
  endtask

  task automatic test_latency();
    do_reset();
    input_valid = 1'b1; input_data = 8'hA5; output_ready = 1'b1;
    #1;
    checks++;
    if (output_valid !== 1'b0) begin
      errors++; $display("FAIL lat_no_bypass: got ov=%b want 0", output_valid);
    end
    drive_cycle(1'b1, 8'hA5, 1'b1);
    checks++;
    if (output_valid !== 1'b1 || output_data !== 8'hA5) begin
      errors++; $display("FAIL lat_visible: got ov=%b data=%h want ov=1 data=a5", output_valid, output_data);
    end
    drive_cycle(1'b0, '0, 1'b1);
    checks++;
    if (output_valid !== 1'b0 || dut.count !== mq.size()) begin
      errors++; $display("FAIL lat_empty: got ov=%b count=%0d want ov=0 count=%0d", output_valid, dut.count, mq.size());
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b1, WIDTH'($urandom), 1'b0);
    end
    input_valid = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (output_valid !== 1'b0 || input_ready !== 1'b0) begin
      errors++; $display("FAIL areset_now: got ov=%b ir=%b want 0 0", output_valid, input_ready);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    mq.delete(); pushes = 0; pops = 0;
    drive_cycle(1'b0, '0, 1'b0);
    checks++;
    if (dut.count !== '0 || input_ready !== 1'b1 || output_valid !== 1'b0) begin
      errors++;
      $display("FAIL areset_after: got count=%0d ir=%b ov=%b want 0 1 0", dut.count, input_ready, output_valid);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      drive_cycle(($urandom_range(0, 99) < 55), WIDTH'($urandom), ($urandom_range(0, 99) < 50));
      checks++;
      if (output_valid !== (mq.size() != 0) || input_ready !== (mq.size() != DEPTH)) begin
        errors++;
        $display("FAIL rand_flags@%0d: got ov=%b ir=%b want ov=%b ir=%b",
                 c, output_valid, input_ready, mq.size() != 0, mq.size() != DEPTH);
      end
      if (mq.size() > 0) begin
        checks++;
        if (output_data !== mq[0]) begin
          errors++; $display("FAIL rand_head@%0d: got %h want %h", c, output_data, mq[0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_hold();
    test_full_no_bypass();
    test_stream();
    test_latency();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
